// File: rtl/chase_pkg.sv
// ============================================================================
// chase_pkg : mode encodings, path tables and config type for the chaser
// Rev 1.0
// ============================================================================
`default_nettype none

package chase_pkg;

   typedef enum logic [1:0] {
      MODE_FIG8   = 2'b00,
      MODE_CIRCLE = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_FLASH  = 2'b11
   } mode_t;

   localparam logic [2:0] FIG8_LAST   = 3'd7;
   localparam logic [2:0] CIRCLE_LAST = 3'd5;

   // Segment index per path position, element 0 first (a=0 .. g=6).
   localparam logic [7:0][2:0] FIG8_SEG   = {3'd5, 3'd6, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd0};
   // Circle has six positions; the top two entries are never addressed.
   localparam logic [7:0][2:0] CIRCLE_SEG = {3'd0, 3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

   localparam logic [6:0] STRIKE_ALL = 7'h7F;

   typedef struct packed {
      logic [2:0] speed;
      logic       dir;
      mode_t      mode;
      logic       run;
   } cfg_t;

   localparam cfg_t CFG_RESET = '{speed: 3'd0, dir: 1'b1, mode: MODE_FIG8, run: 1'b0};

   function automatic logic [6:0] seg_onehot(input logic [2:0] seg);
      seg_onehot = 7'd1 << seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/chase_path_step.sv
// ============================================================================
// chase_path_step : next path position / bounce direction and strike vector
// Rev 1.0
// ============================================================================
`default_nettype none

module chase_path_step
   import chase_pkg::*;
(
   input  mode_t      mode,
   input  logic [2:0] pos,
   input  logic       dir,
   input  logic       bdir,
   input  mode_t      strike_mode,
   input  logic [2:0] strike_pos,
   output logic [2:0] next_pos,
   output logic       next_bdir,
   output logic [6:0] strike
);

   always_comb begin
      next_pos  = pos;
      next_bdir = bdir;
      case (mode)
         MODE_FIG8: begin
            if (dir) next_pos = (pos == FIG8_LAST) ? 3'd0 : pos + 3'd1;
            else     next_pos = (pos == 3'd0) ? FIG8_LAST : pos - 3'd1;
         end
         MODE_CIRCLE: begin
            if (dir) next_pos = (pos == CIRCLE_LAST) ? 3'd0 : pos + 3'd1;
            else     next_pos = (pos == 3'd0) ? CIRCLE_LAST : pos - 3'd1;
         end
         MODE_BOUNCE: begin
            // Reflect off either end of the circle instead of wrapping.
            if (bdir) begin
               if (pos == CIRCLE_LAST) begin
                  next_pos  = CIRCLE_LAST - 3'd1;
                  next_bdir = 1'b0;
               end else begin
                  next_pos  = pos + 3'd1;
               end
            end else begin
               if (pos == 3'd0) begin
                  next_pos  = 3'd1;
                  next_bdir = 1'b1;
               end else begin
                  next_pos  = pos - 3'd1;
               end
            end
         end
         default: next_pos = 3'd0;
      endcase
   end

   always_comb begin
      strike = '0;
      case (strike_mode)
         MODE_FIG8:   strike = seg_onehot(FIG8_SEG[strike_pos]);
         MODE_CIRCLE: strike = seg_onehot(CIRCLE_SEG[strike_pos]);
         MODE_BOUNCE: strike = seg_onehot(CIRCLE_SEG[strike_pos]);
         default:     strike = STRIKE_ALL;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/chase_sequencer.sv
// ============================================================================
// chase_sequencer : step timer, path position and fade divider for the chaser
// Rev 1.0
// ============================================================================
`default_nettype none

module chase_sequencer
   import chase_pkg::*;
#(
   parameter int STEP_CNT_W = 23,
   parameter int FADE_DIV_W = 22
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [2:0] cfg_speed,
   input  logic       cfg_dir,
   input  logic [1:0] cfg_mode,
   input  logic       cfg_run,
   output logic [6:0] strike,
   output logic       step_pulse,
   output logic       fade_tick,
   output logic [2:0] pos,
   output logic       running
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [STEP_CNT_W-1:0] TIMER_ONE = {{(STEP_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [FADE_DIV_W-1:0] FADE_ONE  = {{(FADE_DIV_W-1){1'b0}}, 1'b1};

   state_t                state;
   cfg_t                  active;
   cfg_t                  shadow;
   logic                  bdir;
   logic [STEP_CNT_W-1:0] timer;
   logic [FADE_DIV_W-1:0] fade_cnt;

   logic [STEP_CNT_W-1:0] step_last;
   logic                  boundary;
   logic                  apply;
   cfg_t                  next_cfg;
   logic [2:0]            moved_pos;
   logic                  moved_bdir;
   logic [2:0]            new_pos;
   logic                  new_bdir;
   logic [6:0]            strike_vec;

   // (speed+1) << k, minus one, is just speed in the top bits over all-ones.
   assign step_last = {active.speed, {(STEP_CNT_W-3){1'b1}}};
   assign boundary  = (state == ST_RUN) && (timer == step_last);
   assign apply     = ~cfg_ready && ((state == ST_IDLE) || boundary);
   assign next_cfg  = apply ? shadow : active;

   // Motion uses the old config; a mode switch then restarts the new path at 0.
   always_comb begin
      new_pos  = boundary ? moved_pos : pos;
      new_bdir = boundary ? moved_bdir : bdir;
      if (apply) begin
         new_bdir = shadow.dir;
         if (shadow.mode != active.mode) new_pos = 3'd0;
      end
   end

   chase_path_step u_path_step (
      .mode        (active.mode),
      .pos         (pos),
      .dir         (active.dir),
      .bdir        (bdir),
      .strike_mode (next_cfg.mode),
      .strike_pos  (new_pos),
      .next_pos    (moved_pos),
      .next_bdir   (moved_bdir),
      .strike      (strike_vec)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         active     <= CFG_RESET;
         shadow     <= CFG_RESET;
         bdir       <= 1'b1;
         timer      <= '0;
         fade_cnt   <= '0;
         pos        <= 3'd0;
         cfg_ready  <= 1'b1;
         strike     <= '0;
         step_pulse <= 1'b0;
         fade_tick  <= 1'b0;
         running    <= 1'b0;
      end else begin
         fade_cnt   <= fade_cnt + FADE_ONE;
         fade_tick  <= &fade_cnt;
         strike     <= '0;
         step_pulse <= 1'b0;
         active     <= next_cfg;
         pos        <= new_pos;
         bdir       <= new_bdir;

         if (cfg_valid && cfg_ready) begin
            shadow    <= cfg_t'({cfg_speed, cfg_dir, cfg_mode, cfg_run});
            cfg_ready <= 1'b0;
         end else if (apply) begin
            cfg_ready <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               timer <= '0;
               if (next_cfg.run) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
                  strike  <= strike_vec;
               end
            end
            default: begin
               if (boundary) begin
                  timer <= '0;
                  if (next_cfg.run) begin
                     strike     <= strike_vec;
                     step_pulse <= 1'b1;
                  end else begin
                     state   <= ST_IDLE;
                     running <= 1'b0;
                  end
               end else begin
                  timer <= timer + TIMER_ONE;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/chase_sequencer.md
# chase_sequencer

Step scheduler for the seven-segment chaser.
- Owns the step timer, the path position and the fade divider.
- Emits one-cycle "strike" commands (one-hot segment to light at full intensity) and "fade" ticks to the downstream segment fade/PWM engine.
- Configuration (speed, direction, path mode, run/stop) arrives over a valid/ready handshake and is applied only at step boundaries, so the animation never glitches mid-step.

## Interface
Parameters:
- STEP_CNT_W, 23, step timer width; step period P = (speed+1) << (STEP_CNT_W-3) cycles.
- FADE_DIV_W, 22, fade divider width; fade_tick period = 2^FADE_DIV_W cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  high when no configuration is pending.
- cfg_speed  in  3  step period select; 0 is fastest.
- cfg_dir  in  1  1 = forward (increasing pos), 0 = backward.
- cfg_mode  in  2  path mode:
  - 00 = figure-8 (8 steps).
  - 01 = circle (6 steps).
  - 10 = bounce (circle path, ping-pong).
  - 11 = flash (all segments).
- cfg_run  in  1  1 = run, 0 = stop.
- strike  out  7  one-hot (or all-ones in flash) segment strike, one cycle.
- step_pulse  out  1  one cycle per completed step.
- fade_tick  out  1  one cycle per fade period.
- pos  out  3  current path position.
- running  out  1  state == RUN.

## Operation
- Active config registers: speed, dir, mode, run. Shadow register: one pending config plus a pending flag.
- Handshake:
  - Transfer occurs on a clock edge with cfg_valid & cfg_ready; the fields are captured into the shadow and pending is set.
  - cfg_ready = ~pending.
- FSM states are IDLE and RUN.
- IDLE: timer held at 0; strike = 0, step_pulse = 0.
  - If pending: apply it on the next edge and clear pending.
  - If the applied run = 1, go to RUN.
- RUN: timer counts 0..P-1. The cycle with timer == P-1 is a boundary:
  - Timer returns to 0.
  - pos advances per the active mode and dir.
  - If pending, the shadow is applied on the same edge. Path motion at that edge uses the old config; the new config governs from the next step.
  - If the applied run = 0, go to IDLE.
- Paths (segment index a=0…g=6):
  - Figure-8, pos 0..7 → segments 0,1,6,4,3,2,6,5.
  - Circle, pos 0..5 → segments 0,1,2,3,4,5.
- Wrap rules:
  - Figure-8: 7 forward wraps to 0; 0 backward wraps to 7.
  - Circle: 5 forward wraps to 0; 0 backward wraps to 5.
- Bounce: an internal bdir is loaded from dir whenever the mode is applied.
  - At pos 5 with bdir = forward: bdir flips and pos goes to 4.
  - At pos 0 with bdir = backward: bdir flips and pos goes to 1.
- Flash: pos stays 0; strike = 7'h7F on every step.
- Applying a config whose mode differs from the active mode forces pos = 0. Speed and dir changes alone keep pos.
- fade_tick comes from a free-running FADE_DIV_W counter, independent of state and config.

## Timing
- Reset values:
  - All outputs 0; cfg_ready = 1.
  - pos = 0, timer = 0, fade counter = 0, pending = 0, bdir = 1.
  - Active config: speed = 0, dir = 1, mode = 00, run = 0. State = IDLE.
- All outputs are registered.
- Cycle after IDLE→RUN: strike = onehot(path[pos]), step_pulse = 0.
- Cycle after each boundary edge: step_pulse = 1 and strike = onehot(path[new pos]).
- Consecutive step_pulses are exactly P cycles apart.
- Leaving RUN on a boundary edge: no strike or step_pulse is issued that cycle.
- fade_tick asserts on the cycle after the fade counter = all-ones.
- Reset mid-operation overrides everything, including a pending config, on that edge.

## Structure
- Shared package chase_pkg holds:
  - Mode encodings (MODE_FIG8, MODE_CIRCLE, MODE_BOUNCE, MODE_FLASH).
  - Path lengths and segment lookup tables.
  - The config struct type.
- One sub-module, chase_path_step, is purely combinational: it maps (mode, pos, dir/bdir) to the next pos and bdir, and computes the strike vector.

## Test plan
Bench parameters: STEP_CNT_W = 6, FADE_DIV_W = 4 (speed 0 gives P = 8).
- Handshake/start: from reset, offer run=1, mode=00, dir=1, speed=0 → accepted (cfg_ready drops for 1 cycle). Strike sequence 01,02,40,10,08,04,40,20,01 hex; step_pulse every 8 cycles.
- Backward circle: mode=01, dir=0, speed=1 → pos 0,5,4,3,…; step_pulse 16 cycles apart.
- Bounce: mode=10, dir=1 → pos 0,1,2,3,4,5,4,…,0,1; strikes follow pos.
- Mid-step config: offer speed=3 during a step → cfg_ready stays low until the next boundary. The current step keeps P = 8; the following step has P = 32; pos is unchanged by a speed-only change.
- Stop/flash/reset:
  - Offer run=0 → running drops at the next boundary, with no strike that cycle.
  - Mode=11 → strike = 7F every step.
  - Asserting reset mid-step → all outputs 0 and cfg_ready = 1 next cycle.
- fade_tick: pulses every 16 cycles in IDLE and RUN alike.
